muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 173 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one operand bit per cycle, fixed
// latency of XLEN RUN cycles. The divider datapath (ops 100..111) is built
// only when MULDIV_DIV_EN is defined; otherwise those ops complete
// immediately with result 0.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;
`ifdef MULDIV_DIV_EN
  logic              bzero_q, bzero_d;
`endif

  logic              sgn_a, sgn_b, neg_a, neg_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, step_next, mul_full;
  logic [XLEN-1:0]   mul_res, fin_result;
`ifdef MULDIV_DIV_EN
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   quo, rem;
`endif

  // Operand sign decode and magnitudes; the datapath always works on magnitudes
  always_comb begin
    sgn_a = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    sgn_b = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    neg_a = sgn_a & A[XLEN-1];
    neg_b = sgn_b & B[XLEN-1];
    mag_a = neg_a ? -A : A;
    mag_b = neg_b ? -B : B;
  end

  // One iteration: shift-add multiply step, or restoring divide step
  always_comb begin
    mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    mul_next = {mul_sum, prod_q[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
    // {remainder, quotient} shifted left; a borrow means keep the old remainder
    div_diff = prod_q[2*XLEN-1:XLEN-1] - {1'b0, mcand_q};
    div_next = div_diff[XLEN] ? {prod_q[2*XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    step_next = op_q[2] ? div_next : mul_next;
`else
    step_next = mul_next;
`endif
  end

  // Sign correction and half selection applied to the final iteration
  always_comb begin
    mul_full = neg_q ? -step_next : step_next;
    mul_res  = (op_q[1:0] == 2'b00) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
    quo = step_next[XLEN-1:0];
    rem = step_next[2*XLEN-1:XLEN];
    if (!op_q[2]) begin
      fin_result = mul_res;
    end else if (!op_q[1]) begin
      // Divide by zero yields all ones regardless of sign
      fin_result = bzero_q ? '1 : (neg_q ? -quo : quo);
    end else begin
      fin_result = neg_q ? -rem : rem;
    end
`else
    fin_result = op_q[2] ? '0 : mul_res;
`endif
  end

  // Next-state, operand capture and iteration control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    neg_d    = neg_q;
    result_d = result_q;
`ifdef MULDIV_DIV_EN
    bzero_d  = bzero_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          op_d    = op;
          cnt_d   = '0;
          mcand_d = mag_a;
          prod_d  = {{XLEN{1'b0}}, mag_b};
          neg_d   = neg_a ^ neg_b;
          state_d = RUN;
`ifdef MULDIV_DIV_EN
          bzero_d = (B == '0);
          if (op[2]) begin
            mcand_d = mag_b;
            prod_d  = {{XLEN{1'b0}}, mag_a};
            // Remainder follows the dividend, quotient the sign product
            neg_d   = op[1] ? neg_a : (neg_a ^ neg_b);
          end
`else
          if (op[2]) begin
            state_d  = DONE;
            result_d = '0;
          end
`endif
        end
      end
      RUN: begin
        prod_d = step_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN - 1)) begin
          state_d  = DONE;
          result_d = fin_result;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
`ifdef MULDIV_DIV_EN
      bzero_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      neg_q    <= neg_d;
      result_q <= result_d;
`ifdef MULDIV_DIV_EN
      bzero_q  <= bzero_d;
`endif
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign zero   = (result_q == '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed corner cases,
// randomized ops against an arithmetic reference model, protocol checks.
module tb_muldiv_unit;

  localparam int XLEN = 32;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [2:0]      op_i = 3'b000;
  logic [XLEN-1:0] a_i = '0;
  logic [XLEN-1:0] b_i = '0;
  logic            busy, done, zero;
  logic [XLEN-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op_i),
    .A(a_i), .B(b_i), .busy(busy), .done(done), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: RV32M semantics from plain integer arithmetic
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int          ai, bi;
    longint      la, lb;
    logic [63:0] p;
    ai = a; bi = b; la = ai; lb = bi;
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = la * lb; return p[63:32]; end
      3'd2: begin p = la * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      default: begin
        if (!DIV_EN) return 32'd0;
        case (op)
          3'd4: if (b == 0) return 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                else return 32'(ai / bi);
          3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
          3'd6: if (b == 0) return a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                else return 32'(ai % bi);
          default: return (b == 0) ? a : a % b;
        endcase
      end
    endcase
  endfunction

  // One transaction; optional stray start pulse during RUN cycle 'glitch'
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int glitch);
    int n, busy_n, lat;
    lat = (op[2] && !DIV_EN) ? 1 : XLEN + 1;
    @(negedge clk);
    start = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1; busy_n = 0;
    while (!done && n < 200) begin
      if (busy) busy_n++;
      if (n == glitch) begin
        start = 1'b1; op_i = op ^ 3'b001; a_i = ~a; b_i = b + 1;
      end else if (n == glitch + 1) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    $display("op=%0d A=0x%08h B=0x%08h -> result=0x%08h exp=0x%08h latency=%0d", op, a, b, result, exp, n);
    check("done_seen", done, 1);
    check("latency", n, lat);
    check("busy_cycles", busy_n, lat - 1);
    check("busy_in_done", busy, 0);
    check("result", result, exp);
    check("zero_flag", zero, exp == 0);
    @(posedge clk); #1;
    check("done_pulse", done, 0);
    check("result_hold", result, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(1, 50));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n, m, pulses;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    @(negedge clk); reset = 1'b0;

    // Directed corner cases
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 0);
    run_op(3'd1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, DIV_EN ? 32'hFFFF_FFFD : 32'd0, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, DIV_EN ? 32'hFFFF_FFFF : 32'd0, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, DIV_EN ? 32'h8000_0000 : 32'd0, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
    run_op(3'd5, 32'd100, 32'd0, DIV_EN ? 32'hFFFF_FFFF : 32'd0, 0);
    run_op(3'd7, 32'd100, 32'd0, DIV_EN ? 32'd100 : 32'd0, 0);
    run_op(3'd5, 32'd100, 32'd5, DIV_EN ? 32'd20 : 32'd0, 0);

    // Stray start in RUN cycle 5 must not disturb the operation
    run_op(3'd0, 32'd123456, 32'd789, 32'd97406784, 5);

    // Reset during RUN cycle 10 aborts without a done pulse
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    @(negedge clk);
    start = 1'b1; op_i = 3'd0; a_i = 32'd1000; b_i = 32'd1000;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (n < 10) begin @(posedge clk); #1; n++; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    $display("reset in RUN cycle 10 -> busy=%0d done=%0d result=0x%08h", busy, done, result);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_zero", zero, 1);
    pulses = 0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) pulses++; end
    check("abort_no_done", pulses, 0);
    run_op(3'd0, 32'd6, 32'd7, 32'd42, 0);

    // Reset wins over a simultaneous start
    @(negedge clk);
    reset = 1'b1; start = 1'b1; op_i = 3'd0; a_i = 32'd2; b_i = 32'd3;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    $display("reset+start -> busy=%0d result=0x%08h", busy, result);
    check("rst_prio_busy", busy, 0);
    check("rst_prio_result", result, 0);
    @(posedge clk); #1;
    check("rst_prio_idle", busy | done, 0);

    // Start held high across DONE: back-to-back operations
    @(negedge clk);
    start = 1'b1; op_i = 3'd0; a_i = 32'd3; b_i = 32'd5;
    @(posedge clk); #1;
    n = 1;
    while (!done && n < 200) begin @(posedge clk); #1; n++; end
    check("b2b_first_lat", n, XLEN + 1);
    check("b2b_first_res", result, 32'd15);
    a_i = 32'd11; b_i = 32'd13;
    @(posedge clk); #1;
    start = 1'b0;
    m = 1;
    while (!done && m < 200) begin @(posedge clk); #1; m++; end
    $display("back-to-back: first at %0d, second %0d cycles later, result=0x%08h", n, m, result);
    check("b2b_gap", m, XLEN + 1);
    check("b2b_second_res", result, 32'd143);
    @(posedge clk); #1;

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick();
      rb  = pick();
      run_op(rop, ra, rb, model(rop, ra, rb), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
